// File: rtl/quidditch_pkg.sv
// Shared definitions for the match referee: FSM state encoding,
// winner codes and the active-low 7-segment lookup table (gfedcba).
package quidditch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'b00,
        ST_PLAY       = 2'b01,
        ST_GOAL_PAUSE = 2'b10,
        ST_GAME_OVER  = 2'b11
    } match_state_t;

    localparam logic [1:0] WINNER_NONE  = 2'b00;
    localparam logic [1:0] WINNER_TEAM1 = 2'b01;
    localparam logic [1:0] WINNER_TEAM2 = 2'b10;

    // Index is the hex digit; bit 6 = g ... bit 0 = a; a 0 lights the segment.
    localparam logic [6:0] SEG7_LUT [16] = '{
        7'b1000000,  // 0
        7'b1111001,  // 1
        7'b0100100,  // 2
        7'b0110000,  // 3
        7'b0011001,  // 4
        7'b0010010,  // 5
        7'b0000010,  // 6
        7'b1111000,  // 7
        7'b0000000,  // 8
        7'b0010000,  // 9
        7'b0001000,  // A
        7'b0000011,  // b
        7'b1000110,  // C
        7'b0100001,  // d
        7'b0000110,  // E
        7'b0001110   // F
    };

endpackage

// File: rtl/seg7_decoder.sv
// Hex digit to active-low 7-segment code, purely combinational.
module seg7_decoder
    import quidditch_pkg::*;
(
    input  logic [3:0] i_value,
    output logic [6:0] o_seg
);

    assign o_seg = SEG7_LUT[i_value];

endmodule

// File: rtl/match_scoreboard.sv
// Match referee: counts goals from the game logic while in play, sequences
// serve / play / post-goal pause / game over, and drives the score digits.
module match_scoreboard
    import quidditch_pkg::*;
#(
    parameter int WIN_SCORE    = 7,
    parameter int PAUSE_CYCLES = 50_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       team1_score,
    input  logic       team2_score,
    input  logic       start_button,
    output logic       play_enable,
    output logic       ball_reset,
    output logic       serve_dir,
    output logic [3:0] team1_points,
    output logic [3:0] team2_points,
    output logic [1:0] winner,
    output logic [1:0] match_state,
    output logic [6:0] seg_team1,
    output logic [6:0] seg_team2
);

    localparam int               CNT_W      = (PAUSE_CYCLES > 1) ? $clog2(PAUSE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] PAUSE_LOAD = CNT_W'(PAUSE_CYCLES - 1);
    localparam logic [3:0]       WIN_CODE   = 4'(WIN_SCORE);

    // Start button path
    logic r_start_sync1;
    logic r_start_sync2;
    logic r_start_prev;
    logic r_start_evt;

    // Score input path
    logic r_t1;
    logic r_t1_prev;
    logic r_t2;
    logic r_t2_prev;
    logic w_goal1;
    logic w_goal2;

    // Match state
    match_state_t     r_state;
    logic [3:0]       r_t1_pts;
    logic [3:0]       r_t2_pts;
    logic [1:0]       r_winner;
    logic             r_serve_dir;
    logic             r_ball_reset;
    logic [CNT_W-1:0] r_pause_cnt;

    match_state_t     w_state_next;
    logic [3:0]       w_t1_pts_next;
    logic [3:0]       w_t2_pts_next;
    logic [1:0]       w_winner_next;
    logic             w_serve_dir_next;
    logic             w_ball_reset_next;
    logic [CNT_W-1:0] w_pause_cnt_next;
    logic [3:0]       w_t1_inc;
    logic [3:0]       w_t2_inc;

    // Synchronise the raw button and register its rising edge as a one-cycle event
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_start_sync1 <= 1'b0;
            r_start_sync2 <= 1'b0;
            r_start_prev  <= 1'b0;
            r_start_evt   <= 1'b0;
        end else begin
            r_start_sync1 <= start_button;
            r_start_sync2 <= r_start_sync1;
            r_start_prev  <= r_start_sync2;
            r_start_evt   <= r_start_sync2 & ~r_start_prev;
        end
    end

    // Register score levels and keep the previous sample for edge detection
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_t1      <= 1'b0;
            r_t1_prev <= 1'b0;
            r_t2      <= 1'b0;
            r_t2_prev <= 1'b0;
        end else begin
            r_t1      <= team1_score;
            r_t1_prev <= r_t1;
            r_t2      <= team2_score;
            r_t2_prev <= r_t2;
        end
    end

    assign w_goal1  = r_t1 & ~r_t1_prev;
    assign w_goal2  = r_t2 & ~r_t2_prev;
    assign w_t1_inc = r_t1_pts + 4'd1;
    assign w_t2_inc = r_t2_pts + 4'd1;

    // Match FSM state and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_t1_pts     <= 4'd0;
            r_t2_pts     <= 4'd0;
            r_winner     <= WINNER_NONE;
            r_serve_dir  <= 1'b0;
            r_ball_reset <= 1'b0;
            r_pause_cnt  <= '0;
        end else begin
            r_state      <= w_state_next;
            r_t1_pts     <= w_t1_pts_next;
            r_t2_pts     <= w_t2_pts_next;
            r_winner     <= w_winner_next;
            r_serve_dir  <= w_serve_dir_next;
            r_ball_reset <= w_ball_reset_next;
            r_pause_cnt  <= w_pause_cnt_next;
        end
    end

    // Next-state logic: goals score only in PLAY, start only acts in IDLE / GAME_OVER
    always_comb begin
        w_state_next      = r_state;
        w_t1_pts_next     = r_t1_pts;
        w_t2_pts_next     = r_t2_pts;
        w_winner_next     = r_winner;
        w_serve_dir_next  = r_serve_dir;
        w_ball_reset_next = 1'b0;
        w_pause_cnt_next  = r_pause_cnt;

        case (r_state)
            ST_IDLE: begin
                if (r_start_evt) begin
                    w_state_next      = ST_PLAY;
                    w_ball_reset_next = 1'b1;
                    w_serve_dir_next  = 1'b0;
                end
            end

            ST_PLAY: begin
                if (w_goal1 && w_goal2) begin
                    // Simultaneous goals cancel; replay with the same serve.
                    w_state_next     = ST_GOAL_PAUSE;
                    w_pause_cnt_next = PAUSE_LOAD;
                end else if (w_goal1) begin
                    w_t1_pts_next = w_t1_inc;
                    if (w_t1_inc == WIN_CODE) begin
                        w_state_next  = ST_GAME_OVER;
                        w_winner_next = WINNER_TEAM1;
                    end else begin
                        w_state_next     = ST_GOAL_PAUSE;
                        w_pause_cnt_next = PAUSE_LOAD;
                        w_serve_dir_next = 1'b0;
                    end
                end else if (w_goal2) begin
                    w_t2_pts_next = w_t2_inc;
                    if (w_t2_inc == WIN_CODE) begin
                        w_state_next  = ST_GAME_OVER;
                        w_winner_next = WINNER_TEAM2;
                    end else begin
                        w_state_next     = ST_GOAL_PAUSE;
                        w_pause_cnt_next = PAUSE_LOAD;
                        w_serve_dir_next = 1'b1;
                    end
                end
            end

            ST_GOAL_PAUSE: begin
                if (r_pause_cnt == '0) begin
                    w_state_next      = ST_PLAY;
                    w_ball_reset_next = 1'b1;
                end else begin
                    w_pause_cnt_next = r_pause_cnt - 1'b1;
                end
            end

            ST_GAME_OVER: begin
                if (r_start_evt) begin
                    w_state_next      = ST_PLAY;
                    w_ball_reset_next = 1'b1;
                    w_serve_dir_next  = 1'b0;
                    w_t1_pts_next     = 4'd0;
                    w_t2_pts_next     = 4'd0;
                    w_winner_next     = WINNER_NONE;
                end
            end

            default: w_state_next = ST_IDLE;
        endcase
    end

    assign play_enable  = (r_state == ST_PLAY);
    assign ball_reset   = r_ball_reset;
    assign serve_dir    = r_serve_dir;
    assign team1_points = r_t1_pts;
    assign team2_points = r_t2_pts;
    assign winner       = r_winner;
    assign match_state  = r_state;

    // Score digits: index 0 is team 1, index 1 is team 2
    logic [3:0] w_points [2];
    logic [6:0] w_seg    [2];

    assign w_points[0] = r_t1_pts;
    assign w_points[1] = r_t2_pts;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_seg
            seg7_decoder u_dec (
                .i_value (w_points[gi]),
                .o_seg   (w_seg[gi])
            );
        end
    endgenerate

    assign seg_team1 = w_seg[0];
    assign seg_team2 = w_seg[1];

endmodule
